// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one CW-bit down-counter among NREQ requesters.
// Define TIMER_ARB_HOLD_EN to add a hold input that freezes the count in RUN.
module timer_arbiter #(
    parameter  int NREQ = 4,
    parameter  int CW   = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef TIMER_ARB_HOLD_EN
    input  logic               hold,
`endif
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [CW-1:0]      cnt,
    output logic [IW-1:0]      gnt_id
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt_d;
    logic [IW-1:0]   id_d;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_d;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   nxt_ptr;
    logic            found;
    logic            stall;
    logic            owner_req;
    logic [NREQ-1:0] own;

    assign own       = NREQ'(1) << gnt_id;
    assign owner_req = req[gnt_id];
    assign nxt_ptr   = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);

`ifdef TIMER_ARB_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    // Pick the first requester at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // Next-state logic: grant, count down, complete or abort.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        id_d    = gnt_id;
        ptr_d   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    id_d    = sel;
                    cnt_d   = len[int'(sel)*CW +: CW];
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end else if (!stall) begin
                    if (cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = nxt_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            gnt_id <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            gnt_id <= id_d;
            ptr    <= ptr_d;
        end
    end

    assign gnt  = (state == RUN)  ? own : '0;
    assign done = (state == DONE) ? own : '0;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed vector table plus hand sequences for timer_arbiter.
// Hold checks are included when TIMER_ARB_HOLD_EN is defined.
module tb_timer_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt;
    logic [1:0]  gnt_id;
`ifdef TIMER_ARB_HOLD_EN
    logic        hold;
`endif

    timer_arbiter #(.NREQ(4), .CW(4)) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef TIMER_ARB_HOLD_EN
        .hold   (hold),
`endif
        .req    (req),
        .len    (len),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt    (cnt),
        .gnt_id (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic [3:0]  cnt;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic add(input logic r, input logic [3:0] q,
                       input logic [15:0] l, input logic [3:0] g,
                       input logic [3:0] d, input logic b,
                       input logic [3:0] c, input logic [1:0] i);
        vec_t v;
        v.rst = r; v.req = q; v.len = l; v.gnt = g;
        v.done = d; v.busy = b; v.cnt = c; v.id = i;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g,
                           input logic [3:0] d, input logic b,
                           input logic [3:0] c, input logic [1:0] i);
        chk({tag, ".gnt"},    16'(gnt),    16'(g));
        chk({tag, ".done"},   16'(done),   16'(d));
        chk({tag, ".busy"},   16'(busy),   16'(b));
        chk({tag, ".cnt"},    16'(cnt),    16'(c));
        chk({tag, ".gnt_id"}, 16'(gnt_id), 16'(i));
        chk({tag, ".overlap"}, 16'(gnt & done), 16'h0);
    endtask

    initial begin
        // single request, len[0]=3
        add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd3, 2'd0);
        add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd2, 2'd0);
        add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd1, 2'd0);
        add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd0, 2'd0);
        add(1, 4'h1, 16'h0003, 4'h0, 4'h1, 1, 4'd0, 2'd0);
        add(1, 4'h0, 16'h0003, 4'h0, 4'h0, 0, 4'd0, 2'd0);
        add(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, 2'd0);
        // round robin, lengths 2,1,0,3
        add(1, 4'hF, 16'h3012, 4'h1, 4'h0, 1, 4'd2, 2'd0);
        add(1, 4'hF, 16'h3012, 4'h1, 4'h0, 1, 4'd1, 2'd0);
        add(1, 4'hF, 16'h3012, 4'h1, 4'h0, 1, 4'd0, 2'd0);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h1, 1, 4'd0, 2'd0);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h0, 0, 4'd0, 2'd0);
        add(1, 4'hF, 16'h3012, 4'h2, 4'h0, 1, 4'd1, 2'd1);
        add(1, 4'hF, 16'h3012, 4'h2, 4'h0, 1, 4'd0, 2'd1);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h2, 1, 4'd0, 2'd1);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h0, 0, 4'd0, 2'd1);
        add(1, 4'hF, 16'h3012, 4'h4, 4'h0, 1, 4'd0, 2'd2);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h4, 1, 4'd0, 2'd2);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h0, 0, 4'd0, 2'd2);
        add(1, 4'hF, 16'h3012, 4'h8, 4'h0, 1, 4'd3, 2'd3);
        add(1, 4'hF, 16'h3012, 4'h8, 4'h0, 1, 4'd2, 2'd3);
        add(1, 4'hF, 16'h3012, 4'h8, 4'h0, 1, 4'd1, 2'd3);
        add(1, 4'hF, 16'h3012, 4'h8, 4'h0, 1, 4'd0, 2'd3);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h8, 1, 4'd0, 2'd3);
        add(1, 4'hF, 16'h3012, 4'h0, 4'h0, 0, 4'd0, 2'd3);
        add(1, 4'hF, 16'h3012, 4'h1, 4'h0, 1, 4'd2, 2'd0);
        // owner 0 drops out, then a lone zero-length request from 2
        add(1, 4'h0, 16'h3012, 4'h0, 4'h0, 0, 4'd2, 2'd0);
        add(1, 4'h4, 16'h3012, 4'h4, 4'h0, 1, 4'd0, 2'd2);
        add(1, 4'h4, 16'h3012, 4'h0, 4'h4, 1, 4'd0, 2'd2);
        add(1, 4'h0, 16'h3012, 4'h0, 4'h0, 0, 4'd0, 2'd2);
        add(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, 2'd0);
        // abort of requester 1 at cnt=4 with 2 pending; len change ignored
        add(1, 4'h2, 16'h0570, 4'h2, 4'h0, 1, 4'd7, 2'd1);
        add(1, 4'h6, 16'h0570, 4'h2, 4'h0, 1, 4'd6, 2'd1);
        add(1, 4'h6, 16'h0570, 4'h2, 4'h0, 1, 4'd5, 2'd1);
        add(1, 4'h6, 16'h0570, 4'h2, 4'h0, 1, 4'd4, 2'd1);
        add(1, 4'h4, 16'h0570, 4'h0, 4'h0, 0, 4'd4, 2'd1);
        add(1, 4'h4, 16'h0570, 4'h4, 4'h0, 1, 4'd5, 2'd2);
        add(1, 4'h4, 16'h0F70, 4'h4, 4'h0, 1, 4'd4, 2'd2);

        rst = 1'b0;
        req = '0;
        len = '0;
`ifdef TIMER_ARB_HOLD_EN
        hold = 1'b0;
`endif
        #2;
        chk_all("reset", 4'h0, 4'h0, 1'b0, 4'd0, 2'd0);
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            rst = tbl[k].rst;
            req = tbl[k].req;
            len = tbl[k].len;
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", k), tbl[k].gnt, tbl[k].done,
                    tbl[k].busy, tbl[k].cnt, tbl[k].id);
        end

        // asynchronous reset while cnt=5
        rst = 1'b0;
        req = 4'h0;
        #1;
        rst = 1'b1;
        req = 4'h1;
        len = 16'h0009;
        @(posedge clk);
        #1;
        chk_all("ar_grant", 4'h1, 4'h0, 1'b1, 4'd9, 2'd0);
        repeat (4) @(posedge clk);
        #1;
        chk_all("ar_cnt5", 4'h1, 4'h0, 1'b1, 4'd5, 2'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("ar_async", 4'h0, 4'h0, 1'b0, 4'd0, 2'd0);
        rst = 1'b1;
        req = 4'h3;
        @(posedge clk);
        #1;
        chk_all("ar_after", 4'h1, 4'h0, 1'b1, 4'd9, 2'd0);

`ifdef TIMER_ARB_HOLD_EN
        // hold for 3 cycles at cnt=2 delays done by 3
        rst = 1'b0;
        req = 4'h0;
        #1;
        rst = 1'b1;
        req = 4'h1;
        len = 16'h0003;
        @(posedge clk);
        #1;
        chk_all("h_grant", 4'h1, 4'h0, 1'b1, 4'd3, 2'd0);
        @(posedge clk);
        #1;
        chk_all("h_cnt2", 4'h1, 4'h0, 1'b1, 4'd2, 2'd0);
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("h_hold%0d", h), 4'h1, 4'h0, 1'b1, 4'd2, 2'd0);
        end
        hold = 1'b0;
        @(posedge clk);
        #1;
        chk_all("h_cnt1", 4'h1, 4'h0, 1'b1, 4'd1, 2'd0);
        @(posedge clk);
        #1;
        chk_all("h_cnt0", 4'h1, 4'h0, 1'b1, 4'd0, 2'd0);
        @(posedge clk);
        #1;
        chk_all("h_done", 4'h0, 4'h1, 1'b1, 4'd0, 2'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one CW-bit down-counter between NREQ requesters; each requester asks for a delay of len cycles.
- Round-robin arbiter grants one requester at a time, loads the counter with that requester's length, counts down to zero, then pulses that requester's done line.
- Sits between the counter datapath and the blocks that need timed waits.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 4, counter/length width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- len  input  NREQ*CW  packed lengths; requester i uses len[i*CW +: CW].
- gnt  output  NREQ  one-hot grant; high while the owner's count runs.
- done  output  NREQ  one-hot, one-cycle completion pulse to the owner.
- busy  output  1  high in RUN and DONE states.
- cnt  output  CW  current counter value.
- gnt_id  output  $clog2(NREQ)  index of the current/last owner.

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, done=0, busy=0, cnt=0, gnt_id=0, rr pointer=0 (requester 0 has highest priority first).
- States: IDLE, RUN, DONE.
- IDLE: if req!=0, select the first set bit scanning from the pointer upward, wrapping modulo NREQ. At the next edge:
  - gnt=onehot(sel), gnt_id=sel, cnt=len[sel], busy=1, state=RUN.
  - If req==0, stay in IDLE; cnt holds its value.
- RUN, cnt!=0 and req[gnt_id]=1: cnt decrements by 1 per cycle.
- RUN, cnt==0 and req[gnt_id]=1: next edge goes to DONE, done=onehot(gnt_id), gnt=0.
- Latency: from first cycle gnt is high to the done pulse = len+1 cycles. len=0 gives 1 RUN cycle then DONE.
- DONE: exactly one cycle; done high, busy high. Next edge: done=0, busy=0, pointer=gnt_id+1 (mod NREQ), state=IDLE.
- Minimum gap between done and the next gnt is 1 IDLE cycle.
- Abort: owner drops req[gnt_id] in RUN → next edge to IDLE, gnt=0, busy=0, no done pulse, pointer=gnt_id+1 (mod NREQ). cnt freezes at its current value.
- len is sampled only on the grant edge; later changes are ignored.
- Requests from non-owners while busy are held pending and arbitrated at the next IDLE. No preemption.
- Simultaneous requests in IDLE: round-robin from the pointer. The requester just served has lowest priority next time.
- No wrap: cnt never decrements below 0 (no underflow to all-ones).
- Reset mid-RUN: all outputs return to reset values immediately; no done pulse.
- gnt and done are never both high for any bit.

Optional Feature:
- Macro TIMER_ARB_HOLD_EN.
- When defined: adds input port hold (1 bit). While hold=1 in RUN, cnt does not decrement and the cnt==0 → DONE transition is blocked. IDLE and DONE are unaffected by hold. Abort still takes priority over hold.
- When undefined: no hold port; behaviour exactly as above.

Test Plan:
- Reset then single request: req=0001, len[0]=3 → gnt=0001 one edge later; cnt 3,2,1,0; done=0001 for one cycle 4 cycles after gnt rises; busy low 1 cycle after done.
- Round-robin: req=1111 held, lengths 2,1,0,3 → grants in order 0,1,2,3,0; each done pulse matches its owner; a 1-cycle IDLE gap precedes each grant.
- Zero length: req=0100, len[2]=0 → gnt=0100 for 1 cycle, then done=0100 for 1 cycle, cnt=0.
- Abort: req[1] granted with len=7, drop req[1] when cnt=4 → gnt=0 next edge, done never pulses, cnt stays 4, next grant goes to requester 2 if pending.
- Async reset mid-RUN: assert rst=0 between edges while cnt=5 → gnt, busy, cnt, done all 0 without waiting for clk; after release requester 0 wins a 0011 request.
- TIMER_ARB_HOLD_EN: len=3, hold=1 for 3 cycles when cnt=2 → cnt stays 2 for 3 cycles; done is delayed by exactly 3 cycles versus the no-hold case.
